// File: rtl/vga_config_regfile.sv
// vga_config_regfile
//   Double-buffered configuration register file for a VGA timing/colour block.
//   The bus writes a shadow copy of each register; the shadow set is copied
//   into the active set (driven on cfg_out) only on a frame_start pulse, so
//   the display never sees a configuration change mid-frame.
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   address        in   [ADDR_W]  transaction address (0 = restore defaults)
//   data           in   [DATA_W]  write data; all-ones means "read"
//   valid          in   transaction request, sampled only when idle
//   frame_start    in   commit strobe (shadow -> active)
//   ack            out  one-cycle accept pulse
//   nack           out  one-cycle reject pulse (unmapped address)
//   data_out       out  [DATA_W] read data, zero unless data_out_valid
//   data_out_valid out  one-cycle read-data strobe
//   cfg_out        out  [NUM_REGS*DATA_W] active register values
//   update_pending out  shadow holds writes not yet committed

module vga_config_regfile #(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BASE_ADDR = 32'hC,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data,
  input  logic                         valid,
  input  logic                         frame_start,
  output logic                         ack,
  output logic                         nack,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_out_valid,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
  output logic                         update_pending
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic              pending_q, pending_d;
  logic              ack_q, ack_d;
  logic              nack_q, nack_d;
  logic              dvalid_q, dvalid_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  // Decode. The address is widened to 32 bits before comparing so that a
  // register window reaching past the top of the address space never wraps
  // back onto low addresses.
  logic [31:0]      addr_ext;
  logic             take;
  logic             in_range;
  logic             is_clear;
  logic             is_read;
  logic             is_write;
  logic             is_reject;
  logic [IDX_W-1:0] reg_idx;

  assign addr_ext  = 32'(address);
  assign take      = (state_q == ST_IDLE) && valid;
  assign in_range  = (addr_ext >= BASE_ADDR) && (addr_ext < BASE_ADDR + NUM_REGS);
  assign reg_idx   = IDX_W'(addr_ext - BASE_ADDR);
  // Address 0 restores defaults even if the register window also covers 0.
  assign is_clear  = take && (address == '0);
  assign is_read   = take && !is_clear && in_range && (data == '1);
  assign is_write  = take && !is_clear && in_range && (data != '1);
  assign is_reject = take && !is_clear && !in_range;

  always_comb begin
    state_d   = take ? ST_RESP : ST_IDLE;
    ack_d     = is_clear || is_read || is_write;
    nack_d    = is_reject;
    dvalid_d  = is_read;
    dout_d    = is_read ? shadow_q[reg_idx] : '0;
    // A bus update on the same edge as frame_start wins: the old shadow is
    // committed, and the new value remains pending for the next frame.
    pending_d = pending_q;
    if (is_clear || is_write) begin
      pending_d = 1'b1;
    end else if (frame_start) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      dvalid_q  <= dvalid_d;
      dout_q    <= dout_d;
    end
  end

  // Register storage. frame_start copies the shadow value sampled before
  // this edge, so a same-edge write is naturally deferred by one frame.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!rst_n) begin
        shadow_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        active_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end else begin
        if (is_clear) begin
          shadow_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        end else if (is_write && (reg_idx == IDX_W'(i))) begin
          shadow_q[i] <= data;
        end
        if (frame_start) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_cfg
    assign cfg_out[gi*DATA_W +: DATA_W] = active_q[gi];
  end

  assign ack            = ack_q;
  assign nack           = nack_q;
  assign data_out       = dout_q;
  assign data_out_valid = dvalid_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_vga_config_regfile.sv
// tb_vga_config_regfile
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A transaction-level model tracks shadow/active contents and the
//   expected response of each cycle; a negedge process compares every output
//   against it.

module tb_vga_config_regfile;

  localparam int NR   = 4;
  localparam int DW   = 4;
  localparam int AW   = 4;
  localparam int BASE = 'hC;
  localparam int ALL1 = (1 << DW) - 1;
  localparam logic [NR*DW-1:0] RV = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     address = '0;
  logic [DW-1:0]     data = '0;
  logic              valid = 1'b0;
  logic              frame_start = 1'b0;
  logic              ack;
  logic              nack;
  logic [DW-1:0]     data_out;
  logic              data_out_valid;
  logic [NR*DW-1:0]  cfg_out;
  logic              update_pending;

  vga_config_regfile #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data), .valid(valid),
    .frame_start(frame_start), .ack(ack), .nack(nack), .data_out(data_out),
    .data_out_valid(data_out_valid), .cfg_out(cfg_out),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rv(input int i);
    logic [NR*DW-1:0] v;
    v = RV;
    return int'(v[i*DW +: DW]);
  endfunction

  // ---------------- reference model ----------------
  int sh [NR];
  int act [NR];
  int nsh [NR];
  bit busy = 0;
  bit m_ack = 0, m_nack = 0, m_dov = 0, m_pend = 0;
  int m_dout = 0;
  bit started = 0;
  bit m_wr;
  int m_a;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        sh[i]  = rv(i);
        act[i] = rv(i);
      end
      busy = 0; m_ack = 0; m_nack = 0; m_dov = 0; m_dout = 0; m_pend = 0;
    end else begin
      m_a = int'(address);
      m_wr = 0; m_ack = 0; m_nack = 0; m_dov = 0; m_dout = 0;
      for (int i = 0; i < NR; i++) nsh[i] = sh[i];
      if (!busy && valid) begin
        busy = 1;
        if (m_a == 0) begin
          for (int i = 0; i < NR; i++) nsh[i] = rv(i);
          m_wr = 1; m_ack = 1;
        end else if (m_a >= BASE && m_a < BASE + NR) begin
          m_ack = 1;
          if (int'(data) == ALL1) begin
            m_dov = 1; m_dout = sh[m_a - BASE];
          end else begin
            nsh[m_a - BASE] = int'(data); m_wr = 1;
          end
        end else begin
          m_nack = 1;
        end
      end else begin
        busy = 0;
      end
      if (frame_start) for (int i = 0; i < NR; i++) act[i] = sh[i];
      if (m_wr) m_pend = 1;
      else if (frame_start) m_pend = 0;
      for (int i = 0; i < NR; i++) sh[i] = nsh[i];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("ack", int'(ack), int'(m_ack));
      chk("nack", int'(nack), int'(m_nack));
      chk("data_out_valid", int'(data_out_valid), int'(m_dov));
      chk("data_out", int'(data_out), m_dout);
      chk("update_pending", int'(update_pending), int'(m_pend));
      for (int i = 0; i < NR; i++)
        chk($sformatf("cfg_out[%0d]", i), int'(cfg_out[i*DW +: DW]), act[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic txn(input int a, input int d);
    address = AW'(a); data = DW'(d); valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
  endtask

  int acks;

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    chk("rst cfg_out", int'(cfg_out), 0);
    chk("rst pending", int'(update_pending), 0);
    chk("rst ack", int'(ack), 0);
    rst_n = 1'b1;
    tick();

    // write 5 to C, held in shadow until frame_start
    address = 4'hC; data = 4'h5; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("wrC ack", int'(ack), 1);
    chk("wrC cfg before commit", int'(cfg_out[3:0]), 0);
    chk("wrC pending", int'(update_pending), 1);
    tick();
    chk("wrC ack drops", int'(ack), 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("wrC cfg after commit", int'(cfg_out[3:0]), 5);
    chk("wrC pending cleared", int'(update_pending), 0);

    // write 6 to D, read it back
    txn('hD, 6);
    address = 4'hD; data = 4'hF; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("rdD ack", int'(ack), 1);
    chk("rdD dov", int'(data_out_valid), 1);
    chk("rdD data", int'(data_out), 6);
    tick();
    chk("rdD data after", int'(data_out), 0);
    chk("rdD dov after", int'(data_out_valid), 0);

    // unmapped address
    address = 4'h3; data = 4'h1; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("nack3 nack", int'(nack), 1);
    chk("nack3 ack", int'(ack), 0);
    tick();

    // write to E on the same edge as frame_start
    address = 4'hE; data = 4'h9; valid = 1'b1; frame_start = 1'b1;
    tick();
    valid = 1'b0; frame_start = 1'b0;
    chk("same-edge cfgE old", int'(cfg_out[11:8]), 0);
    chk("same-edge cfgD committed", int'(cfg_out[7:4]), 6);
    chk("same-edge pending", int'(update_pending), 1);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("next-frame cfgE", int'(cfg_out[11:8]), 9);
    chk("next-frame pending", int'(update_pending), 0);

    // valid held for 6 cycles -> 3 acks on alternate cycles
    acks = 0;
    address = 4'hC; data = 4'h2; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("burst ack cycle %0d", i), int'(ack), (i % 2 == 0) ? 1 : 0);
      acks += int'(ack);
    end
    valid = 1'b0;
    chk("burst ack count", acks, 3);
    tick();

    // restore defaults via address 0
    txn('hF, 7);
    txn(0, 3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("clear cfg_out", int'(cfg_out), int'(RV));

    // reset during RESP, and reset on the accepting edge
    address = 4'hC; data = 4'h3; valid = 1'b1;
    tick();
    valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst in RESP ack", int'(ack), 0);
    rst_n = 1'b1;
    address = 4'hD; data = 4'h4; valid = 1'b1; rst_n = 1'b0;
    tick();
    valid = 1'b0; rst_n = 1'b1;
    chk("rst on accept ack", int'(ack), 0);
    chk("rst on accept pending", int'(update_pending), 0);
    tick();

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       address = '0;
        1:       address = AW'($urandom);
        default: address = AW'(BASE + $urandom_range(0, NR - 1));
      endcase
      data = ($urandom_range(0, 3) == 0) ? DW'(ALL1) : DW'($urandom);
      frame_start = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end
    valid = 1'b0; frame_start = 1'b0; rst_n = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
